// File: rtl/dtree_feature_loader.sv
// Byte-stream front end for a combinational decision tree: assembles a feature vector, holds it
// for a settle time, captures the class and hands it out on a valid/ready channel.
// Optional counters are enabled with `define DTREE_LOADER_STATS_EN.
module dtree_feature_loader #(
    parameter int NUM_FEATURES  = 5,
    parameter int FEAT_W        = 8,
    parameter int CLS_W         = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FEAT_W-1:0]              in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic [NUM_FEATURES*FEAT_W-1:0] feat_bus,
    input  logic [CLS_W-1:0]               cls_in,
    output logic [CLS_W-1:0]               res_class,
    output logic                           res_valid,
    input  logic                           res_ready,
`ifdef DTREE_LOADER_STATS_EN
    output logic [15:0]                    vec_cnt,
    output logic [15:0]                    pos_cnt,
    output logic [7:0]                     err_cnt,
`endif
    output logic                           frame_err
);

    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t                           state_q;
    logic [IDX_W-1:0]                 idx_q;
    logic [3:0]                       cnt_q;
    logic                             in_ready_q;
    logic [NUM_FEATURES*FEAT_W-1:0]   feat_bus_q;
    logic [CLS_W-1:0]                 res_class_q;
    logic                             res_valid_q;
    logic                             frame_err_q;
    logic                             accept_s;
    logic                             handshake_s;

    assign accept_s    = (state_q == ST_LOAD) && in_valid && in_ready_q;
    assign handshake_s = (state_q == ST_RESULT) && res_valid_q && res_ready;

    // Loader state machine with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b0;
            feat_bus_q  <= '0;
            res_class_q <= '0;
            res_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (accept_s) begin
                        if (idx_q == LAST_IDX) begin
                            if (in_last) begin
                                feat_bus_q[int'(idx_q)*FEAT_W +: FEAT_W] <= in_data;
                                idx_q      <= '0;
                                cnt_q      <= SETTLE_LOAD;
                                in_ready_q <= 1'b0;
                                state_q    <= ST_SETTLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                idx_q       <= '0;
                            end
                        end else if (in_last) begin
                            frame_err_q <= 1'b1;
                            idx_q       <= '0;
                        end else begin
                            feat_bus_q[int'(idx_q)*FEAT_W +: FEAT_W] <= in_data;
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    in_ready_q <= 1'b0;
                    cnt_q      <= cnt_q - 4'd1;
                    // cls_in is only trusted here, after the tree has had the full settle time
                    if (cnt_q <= 4'd1) begin
                        res_class_q <= cls_in;
                        state_q     <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end else if (res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        idx_q       <= '0;
                        state_q     <= ST_LOAD;
                    end else begin
                        in_ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_LOAD;
                    idx_q       <= '0;
                    in_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign feat_bus  = feat_bus_q;
    assign res_class = res_class_q;
    assign res_valid = res_valid_q;
    assign frame_err = frame_err_q;

`ifdef DTREE_LOADER_STATS_EN
    logic [15:0] vec_cnt_q;
    logic [15:0] pos_cnt_q;
    logic [7:0]  err_cnt_q;

    // Saturating result and framing-error counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt_q <= 16'd0;
            pos_cnt_q <= 16'd0;
            err_cnt_q <= 8'd0;
        end else begin
            if (handshake_s && (vec_cnt_q != 16'hFFFF)) begin
                vec_cnt_q <= vec_cnt_q + 16'd1;
            end
            if (handshake_s && (res_class_q != '0) && (pos_cnt_q != 16'hFFFF)) begin
                pos_cnt_q <= pos_cnt_q + 16'd1;
            end
            if (frame_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign vec_cnt = vec_cnt_q;
    assign pos_cnt = pos_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Directed bench for dtree_feature_loader with a stub tree: class = (X0 < 24).
module tb_dtree_feature_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [39:0] feat_bus;
    logic [0:0]  cls_in;
    logic [0:0]  res_class;
    logic        res_valid;
    logic        res_ready;
    logic        frame_err;
`ifdef DTREE_LOADER_STATS_EN
    logic [15:0] vec_cnt;
    logic [15:0] pos_cnt;
    logic [7:0]  err_cnt;
`endif

    int checks;
    int failures;
    int lat;

    assign cls_in = (feat_bus[7:0] < 8'd24) ? 1'b1 : 1'b0;

    dtree_feature_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .feat_bus  (feat_bus),
        .cls_in    (cls_in),
        .res_class (res_class),
        .res_valid (res_valid),
        .res_ready (res_ready),
`ifdef DTREE_LOADER_STATS_EN
        .vec_cnt   (vec_cnt),
        .pos_cnt   (pos_cnt),
        .err_cnt   (err_cnt),
`endif
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Returns #1 after the clock edge that accepted the byte
    task automatic send_byte(input logic [7:0] d, input logic l);
        int k;
        k = 0;
        in_data = d; in_valid = 1'b1; in_last = l;
        while (in_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) check_eq("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_vec(input logic [7:0] a, b, c, d, e);
        send_byte(a, 1'b0);
        send_byte(b, 1'b0);
        send_byte(c, 1'b0);
        send_byte(d, 1'b0);
        send_byte(e, 1'b1);
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check_eq("result_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b1;
        #12;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("rst_feat_bus", 64'(feat_bus), 64'd0);
        check_eq("rst_frame_err", 64'(frame_err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector 10,0,0,0,0 classifies as 1 with fixed latency
        send_vec(8'd10, 8'd0, 8'd0, 8'd0, 8'd0);
        check_eq("t1_in_ready_settle", 64'(in_ready), 64'd0);
        wait_result(lat);
        check_eq("t1_latency", 64'(lat), 64'd3);
        check_eq("t1_class", 64'(res_class), 64'd1);
        check_eq("t1_feat_bus", 64'(feat_bus), 64'h000000000A);
        @(posedge clk); #1;
        check_eq("t1_valid_drop", 64'(res_valid), 64'd0);
        check_eq("t1_in_ready_back", 64'(in_ready), 64'd1);

        // Back-pressured result, X0=200 classifies as 0
        res_ready = 1'b0;
        send_vec(8'd200, 8'd1, 8'd2, 8'd3, 8'd4);
        wait_result(lat);
        check_eq("t2_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 10; i++) begin
            check_eq("t2_hold_valid", 64'(res_valid), 64'd1);
            check_eq("t2_hold_class", 64'(res_class), 64'd0);
            check_eq("t2_hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("t2_valid_drop", 64'(res_valid), 64'd0);
        check_eq("t2_in_ready_back", 64'(in_ready), 64'd1);

        // Early in_last on the third byte
        send_byte(8'd7, 1'b0);
        send_byte(8'd8, 1'b0);
        send_byte(8'd9, 1'b1);
        check_eq("t3_frame_err", 64'(frame_err), 64'd1);
        check_eq("t3_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check_eq("t3_frame_err_pulse", 64'(frame_err), 64'd0);
        repeat (4) begin @(posedge clk); #1; end
        check_eq("t3_no_result", 64'(res_valid), 64'd0);
        send_vec(8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
        wait_result(lat);
        check_eq("t3_class", 64'(res_class), 64'd1);
        check_eq("t3_feat_bus", 64'(feat_bus), 64'h0505050505);
        @(posedge clk); #1;

        // Fifth byte without in_last is dropped and idx restarts
        send_byte(8'd1, 1'b0);
        send_byte(8'd2, 1'b0);
        send_byte(8'd3, 1'b0);
        send_byte(8'd4, 1'b0);
        send_byte(8'd99, 1'b0);
        check_eq("t4_frame_err", 64'(frame_err), 64'd1);
        check_eq("t4_dropped_byte", 64'(feat_bus), 64'h0504030201);
        repeat (4) begin @(posedge clk); #1; end
        check_eq("t4_no_result", 64'(res_valid), 64'd0);
        send_vec(8'd3, 8'd6, 8'd7, 8'd8, 8'd9);
        wait_result(lat);
        check_eq("t4_class", 64'(res_class), 64'd1);
        check_eq("t4_feat_bus", 64'(feat_bus), 64'h0908070603);
        @(posedge clk); #1;

        // Asynchronous reset during SETTLE
        send_vec(8'd50, 8'd51, 8'd52, 8'd53, 8'd54);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("t5_rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("t5_rst_res_class", 64'(res_class), 64'd0);
        check_eq("t5_rst_feat_bus", 64'(feat_bus), 64'd0);
`ifdef DTREE_LOADER_STATS_EN
        check_eq("t5_rst_vec_cnt", 64'(vec_cnt), 64'd0);
`endif
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_no_result", 64'(res_valid), 64'd0);
        send_vec(8'd20, 8'd1, 8'd1, 8'd1, 8'd1);
        wait_result(lat);
        check_eq("t5_latency", 64'(lat), 64'd3);
        check_eq("t5_class", 64'(res_class), 64'd1);
        check_eq("t5_feat_bus", 64'(feat_bus), 64'h0101010114);
        @(posedge clk); #1;

`ifdef DTREE_LOADER_STATS_EN
        // Counters cleared by the mid-run reset: two good vectors, then one framing error
        send_vec(8'd200, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_result(lat);
        @(posedge clk); #1;
        send_byte(8'd1, 1'b1);
        @(posedge clk); #1;
        check_eq("stats_vec_cnt", 64'(vec_cnt), 64'd2);
        check_eq("stats_pos_cnt", 64'(pos_cnt), 64'd1);
        check_eq("stats_err_cnt", 64'(err_cnt), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
